rv32i_prog_loader: RTL and testbench
====================================

RV32I_PROG_LOADER -- requirements
Module: rv32i_prog_loader

Interface
REQ-001 Parameter: IMEM_DEPTH, default 256, instruction-memory depth in 32-bit words (max 256).
REQ-002 Parameter: ADDR_W, default 8, width of the word-index write address.
REQ-003 Ports, clock and reset first:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  program stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- restart  input  1  abandon DONE/ERR and re-arm for a new image.
- imem_we  output  1  one-cycle write strobe to core instruction memory.
- imem_addr  output  ADDR_W  word index being written.
- imem_wdata  output  32  assembled instruction word.
- core_rst_n  output  1  active-low reset to rv32i_core; high only after a verified load.
- done  output  1  image loaded and checksum verified.
- error  output  1  load aborted.

Function
REQ-004 A byte transfers only on a cycle where in_valid and in_ready are both high; no other cycle changes stream state.
REQ-005 Stream format: magic 0xA5, length byte N (word count), N*4 payload bytes little-endian per word (first byte = bits 7:0), checksum byte equal to XOR of all payload bytes.
REQ-006 FSM states: IDLE, LEN, DATA, CSUM, DONE, ERR.
REQ-007 IDLE: accepted byte 0xA5 -> LEN; any other byte is discarded, state stays IDLE.
REQ-008 LEN: N==0 or N>IMEM_DEPTH -> ERR; otherwise store N, clear word index, byte counter and running XOR -> DATA.
REQ-009 DATA: each accepted byte is placed in lane byte_cnt (0..3) of the assembly register and XORed into the running checksum; byte_cnt wraps 3->0.
REQ-010 When lane 3 is accepted, imem_we pulses high in the following cycle with imem_addr = current word index and imem_wdata = full word; word index then increments.
REQ-011 After the Nth word's lane-3 byte -> CSUM; the last imem_we pulse occurs in the first CSUM cycle.
REQ-012 CSUM: accepted byte equal to running XOR -> DONE, else -> ERR.
REQ-013 in_ready is high in IDLE, LEN, DATA, CSUM and low in DONE and ERR.
REQ-014 done is high exactly in DONE; error is high exactly in ERR; both registered outputs.
REQ-015 core_rst_n is a registered output, high only in DONE; it is low in every other state, so the core never runs a partial or corrupt image.
REQ-016 restart high in DONE or ERR -> IDLE on the next edge: done, error and core_rst_n drop low together. restart is ignored in IDLE, LEN, DATA and CSUM.
REQ-017 imem_we is never high outside the cycle defined in REQ-010; imem_addr and imem_wdata hold their last values when imem_we is low.
REQ-018 A load in ERR leaves already written imem words in place; no rollback is performed.
REQ-019 in_valid may stall for any number of cycles in any state with no timeout and no state change.

Reset
REQ-020 rst_n low at a rising edge -> state IDLE, in_ready 1, imem_we 0, imem_addr 0, imem_wdata 0, core_rst_n 0, done 0, error 0, byte counter, word index and running XOR cleared.
REQ-021 Reset mid-load (any state) discards the partial image and holds core_rst_n low; the reset cycle produces no imem_we pulse.

Verification
REQ-022 Sum program: stream A5 08, then 8 words 0x00000093, 0x00100113, 0x00600193, 0x002080B3, 0x00110113, 0xFE314CE3, 0x00102023, 0x00100073, then correct XOR byte -> 8 imem_we pulses at addr 0..7 with those words, then done=1 and core_rst_n=1. Core then halts with x1=15 and dmem[0]=15.
REQ-023 Bytes 00 FF A5 01 13 00 00 00 13 -> leading 00 and FF discarded; single write of 0x00000013 at addr 0; XOR 0x13 matches -> done=1.
REQ-024 Same stream with checksum 0x12 -> error=1, done=0, core_rst_n=0, in_ready=0. Then restart=1 for one cycle -> IDLE, error=0, in_ready=1.
REQ-025 Length byte 00, and with IMEM_DEPTH=4 length byte 05 -> ERR immediately, no imem_we.
REQ-026 in_valid randomly deasserted 50% of cycles during REQ-022 -> identical writes and final state. rst_n pulsed low after 6 payload bytes -> IDLE, outputs at reset values, no further writes.

Source files
------------

// File: rtl/rv32i_prog_loader.sv
// Byte-stream program loader for the rv32i core: parses a framed image
// (magic, word count, little-endian payload, XOR checksum) into instruction memory.
module rv32i_prog_loader #(
   parameter int IMEM_DEPTH = 256,
   parameter int ADDR_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              restart,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst_n,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_t;

   localparam logic [7:0] MAGIC = 8'hA5;

   state_t      state;
   logic [7:0]  word_cnt;
   logic [7:0]  word_idx;
   logic [1:0]  byte_cnt;
   logic [7:0]  csum;
   logic [23:0] asm_lo;
   logic        xfer;

   assign xfer = in_valid & in_ready;

   // NOTE: all state and outputs use non-blocking assignments so every branch
   // below sees the pre-edge values of the registers it reads.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         core_rst_n <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         word_cnt   <= '0;
         word_idx   <= '0;
         byte_cnt   <= '0;
         csum       <= '0;
         asm_lo     <= '0;
      end else begin
         // NOTE: default-low here makes imem_we a strict one-cycle pulse; only
         // the lane-3 branch overrides it.
         imem_we <= 1'b0;
         case (state)
            IDLE: begin
               if (xfer && in_data == MAGIC) state <= LEN;
            end
            LEN: begin
               if (xfer) begin
                  if (in_data == 8'd0 || int'(in_data) > IMEM_DEPTH) begin
                     state    <= ERR;
                     in_ready <= 1'b0;
                     error    <= 1'b1;
                  end else begin
                     word_cnt <= in_data;
                     word_idx <= '0;
                     byte_cnt <= '0;
                     csum     <= '0;
                     state    <= DATA;
                  end
               end
            end
            DATA: begin
               if (xfer) begin
                  csum     <= csum ^ in_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  case (byte_cnt)
                     2'd0: asm_lo[7:0]   <= in_data;
                     2'd1: asm_lo[15:8]  <= in_data;
                     2'd2: asm_lo[23:16] <= in_data;
                     default: begin
                        imem_we    <= 1'b1;
                        imem_addr  <= ADDR_W'(word_idx);
                        imem_wdata <= {in_data, asm_lo};
                        word_idx   <= word_idx + 8'd1;
                        if (word_idx == word_cnt - 8'd1) state <= CSUM;
                     end
                  endcase
               end
            end
            CSUM: begin
               if (xfer) begin
                  in_ready <= 1'b0;
                  if (in_data == csum) begin
                     state      <= DONE;
                     done       <= 1'b1;
                     core_rst_n <= 1'b1;
                  end else begin
                     state <= ERR;
                     error <= 1'b1;
                  end
               end
            end
            DONE, ERR: begin
               if (restart) begin
                  state      <= IDLE;
                  in_ready   <= 1'b1;
                  done       <= 1'b0;
                  error      <= 1'b0;
                  core_rst_n <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               in_ready   <= 1'b1;
               done       <= 1'b0;
               error      <= 1'b0;
               core_rst_n <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_prog_loader.sv
// Directed bench for rv32i_prog_loader: cycle-by-cycle vector table plus
// hand-written sequences for full images, stalls, length limits and reset.
module tb_rv32i_prog_loader;

   typedef struct {
      logic        rs;
      logic        vld;
      logic [7:0]  dat;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic        rdy;
      logic        dn;
      logic        er;
      logic        cr;
   } vec_t;

   typedef struct {
      logic [7:0]  a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        restart;

   logic        in_ready, imem_we, core_rst_n, done, error;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;

   logic        s_in_ready, s_imem_we, s_core_rst_n, s_done, s_error;
   logic [1:0]  s_imem_addr;
   logic [31:0] s_imem_wdata;

   int   n_vec = 0;
   int   n_err = 0;
   int   s_writes = 0;
   wr_t  wq[$];
   vec_t tbl[$];

   logic [31:0] words [8] = '{32'h00000093, 32'h00100113, 32'h00600193, 32'h002080B3,
                              32'h00110113, 32'hFE314CE3, 32'h00102023, 32'h00100073};

   always #5 clk = ~clk;

   rv32i_prog_loader #(.IMEM_DEPTH(256), .ADDR_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .restart(restart), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst_n(core_rst_n),
      .done(done), .error(error)
   );

   rv32i_prog_loader #(.IMEM_DEPTH(4), .ADDR_W(2)) u_small (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(s_in_ready), .restart(restart), .imem_we(s_imem_we),
      .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata), .core_rst_n(s_core_rst_n),
      .done(s_done), .error(s_error)
   );

   always @(negedge clk) begin
      if (imem_we) wq.push_back('{a: imem_addr, d: imem_wdata});
      if (s_imem_we) s_writes++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic rs, input logic vld, input logic [7:0] dat,
                      input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic rdy, input logic dn, input logic er, input logic cr);
      tbl.push_back('{rs: rs, vld: vld, dat: dat, we: we, addr: addr, wdata: wdata,
                      rdy: rdy, dn: dn, er: er, cr: cr});
   endtask

   task automatic send(input logic [7:0] b, input bit stall);
      bit xfer = 1'b0;
      int guard = 0;
      while (!xfer && guard < 200) begin
         @(negedge clk);
         in_data  = b;
         in_valid = !(stall && $urandom_range(1) == 0);
         xfer     = in_valid && in_ready;
         guard++;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (!xfer) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic pulse_restart();
      @(negedge clk);
      restart = 1'b1;
      @(posedge clk);
      #1 restart = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_sum(input bit stall, input string tag);
      logic [7:0] x = 8'h00;
      logic [7:0] b;
      wq.delete();
      send(8'hA5, stall);
      send(8'd8, stall);
      for (int w = 0; w < 8; w++) begin
         for (int k = 0; k < 4; k++) begin
            b = words[w][8*k +: 8];
            x ^= b;
            send(b, stall);
         end
      end
      send(x, stall);
      check({tag, "_nwrites"}, wq.size(), 32'd8);
      for (int w = 0; w < 8 && w < wq.size(); w++) begin
         check($sformatf("%s_addr%0d", tag, w), {24'd0, wq[w].a}, w);
         check($sformatf("%s_word%0d", tag, w), wq[w].d, words[w]);
      end
      check({tag, "_ctl"}, {27'd0, in_ready, done, error, core_rst_n, imem_we}, 32'b01010);
   endtask

   initial begin
      int sw;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      restart  = 1'b0;

      // Single-word image, good checksum, with a restart that must be ignored in DATA.
      add(0, 1, 8'h00, 0, 0, 32'h00, 1, 0, 0, 0);
      add(0, 1, 8'hFF, 0, 0, 32'h00, 1, 0, 0, 0);
      add(0, 1, 8'hA5, 0, 0, 32'h00, 1, 0, 0, 0);
      add(0, 1, 8'h01, 0, 0, 32'h00, 1, 0, 0, 0);
      add(0, 1, 8'h13, 0, 0, 32'h00, 1, 0, 0, 0);
      add(1, 0, 8'h00, 0, 0, 32'h00, 1, 0, 0, 0);
      add(0, 1, 8'h00, 0, 0, 32'h00, 1, 0, 0, 0);
      add(0, 1, 8'h00, 0, 0, 32'h00, 1, 0, 0, 0);
      add(0, 1, 8'h00, 1, 0, 32'h13, 1, 0, 0, 0);
      add(0, 0, 8'h00, 0, 0, 32'h13, 1, 0, 0, 0);
      add(0, 1, 8'h13, 0, 0, 32'h13, 0, 1, 0, 1);
      add(0, 1, 8'hA5, 0, 0, 32'h13, 0, 1, 0, 1);
      add(1, 0, 8'h00, 0, 0, 32'h13, 1, 0, 0, 0);
      // Same image with a bad checksum, then restart out of ERR.
      add(0, 1, 8'hA5, 0, 0, 32'h13, 1, 0, 0, 0);
      add(0, 1, 8'h01, 0, 0, 32'h13, 1, 0, 0, 0);
      add(0, 1, 8'h13, 0, 0, 32'h13, 1, 0, 0, 0);
      add(0, 1, 8'h00, 0, 0, 32'h13, 1, 0, 0, 0);
      add(0, 1, 8'h00, 0, 0, 32'h13, 1, 0, 0, 0);
      add(0, 1, 8'h00, 1, 0, 32'h13, 1, 0, 0, 0);
      add(0, 1, 8'h12, 0, 0, 32'h13, 0, 0, 1, 0);
      add(0, 0, 8'h00, 0, 0, 32'h13, 0, 0, 1, 0);
      add(1, 0, 8'h00, 0, 0, 32'h13, 1, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      check("reset_ctl", {27'd0, in_ready, done, error, core_rst_n, imem_we}, 32'b10000);
      check("reset_addr", {24'd0, imem_addr}, 32'd0);
      check("reset_wdata", imem_wdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk);
         restart  = tbl[i].rs;
         in_valid = tbl[i].vld;
         in_data  = tbl[i].dat;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_ctl", i),
               {27'd0, imem_we, in_ready, done, error, core_rst_n},
               {27'd0, tbl[i].we, tbl[i].rdy, tbl[i].dn, tbl[i].er, tbl[i].cr});
         check($sformatf("vec%0d_addr", i), {24'd0, imem_addr}, {24'd0, tbl[i].addr});
         check($sformatf("vec%0d_wdata", i), imem_wdata, tbl[i].wdata);
      end
      restart  = 1'b0;
      in_valid = 1'b0;

      run_sum(1'b0, "sum");
      pulse_restart();
      run_sum(1'b1, "sum_stall");
      pulse_restart();
      check("restart_ctl", {27'd0, in_ready, done, error, core_rst_n, imem_we}, 32'b10000);

      // Zero length aborts immediately.
      wq.delete();
      send(8'hA5, 1'b0);
      send(8'h00, 1'b0);
      check("len0_ctl", {27'd0, in_ready, done, error, core_rst_n, imem_we}, 32'b00100);
      repeat (3) @(posedge clk);
      #1 check("len0_nwrites", wq.size(), 32'd0);
      pulse_restart();

      // Reset in the middle of a load.
      wq.delete();
      send(8'hA5, 1'b0);
      send(8'h08, 1'b0);
      for (int k = 0; k < 6; k++) send(words[k / 4][8*(k % 4) +: 8], 1'b0);
      pulse_reset();
      check("midrst_ctl", {27'd0, in_ready, done, error, core_rst_n, imem_we}, 32'b10000);
      check("midrst_addr", {24'd0, imem_addr}, 32'd0);
      check("midrst_wdata", imem_wdata, 32'd0);
      send(8'h13, 1'b0);
      send(8'h00, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check("midrst_nwrites", wq.size(), 32'd1);
      check("midrst_idle", {30'd0, in_ready, error}, 32'b10);

      // Length limit on the 4-word instance: 5 is rejected, 4 is accepted.
      sw = s_writes;
      send(8'hA5, 1'b0);
      send(8'h05, 1'b0);
      check("depth5_small_err", {30'd0, s_error, s_in_ready}, 32'b10);
      check("depth5_big_ok", {30'd0, error, in_ready}, 32'b01);
      repeat (3) @(posedge clk);
      #1 check("depth5_nwrites", s_writes - sw, 32'd0);
      pulse_reset();
      send(8'hA5, 1'b0);
      send(8'h04, 1'b0);
      check("depth4_small_ok", {30'd0, s_error, s_in_ready}, 32'b01);
      pulse_reset();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
